// File: rtl/fwd_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_sel_ctrl
//  Brief    : EX-stage operand forwarding select generation with load-use
//             hazard detection, stall request and bubble insertion.
//  Revision : 1.0
// ============================================================================
module fwd_sel_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [1:0]            C_SEL_RF  = 2'd0;
    localparam logic [1:0]            C_SEL_MEM = 2'd1;
    localparam logic [1:0]            C_SEL_EX  = 2'd2;
    localparam logic [REG_ADDR_W-1:0] C_REG_ZERO = '0;
    localparam logic [CNT_W-1:0]      C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                  r_ex_wr_en;
    logic                  r_ex_is_load;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_mem_wr_en;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic [1:0]            r_sel_a;
    logic [1:0]            r_sel_b;
    logic [CNT_W-1:0]      r_stall_count;

    logic       w_ex_hit_rs;
    logic       w_ex_hit_rt;
    logic       w_mem_hit_rs;
    logic       w_mem_hit_rt;
    logic       w_stall;
    logic       w_bubble;
    logic [1:0] w_next_sel_a;
    logic [1:0] w_next_sel_b;

    // Register zero is hard-wired, so a producer targeting it never matches.
    assign w_ex_hit_rs  = r_ex_wr_en  && (r_ex_rd  != C_REG_ZERO) && (r_ex_rd  == id_rs) && id_uses_rs;
    assign w_ex_hit_rt  = r_ex_wr_en  && (r_ex_rd  != C_REG_ZERO) && (r_ex_rd  == id_rt) && id_uses_rt;
    assign w_mem_hit_rs = r_mem_wr_en && (r_mem_rd != C_REG_ZERO) && (r_mem_rd == id_rs) && id_uses_rs;
    assign w_mem_hit_rt = r_mem_wr_en && (r_mem_rd != C_REG_ZERO) && (r_mem_rd == id_rt) && id_uses_rt;

    assign w_stall  = ~rst && id_valid && ~flush && r_ex_is_load && (w_ex_hit_rs || w_ex_hit_rt);
    assign w_bubble = w_stall || flush || ~id_valid;

    // The EX stage holds the most recent producer, so it outranks MEM.
    always_comb begin
        w_next_sel_a = C_SEL_RF;
        w_next_sel_b = C_SEL_RF;
        if (w_ex_hit_rs && ~r_ex_is_load) begin
            w_next_sel_a = C_SEL_EX;
        end else if (w_mem_hit_rs) begin
            w_next_sel_a = C_SEL_MEM;
        end
        if (w_ex_hit_rt && ~r_ex_is_load) begin
            w_next_sel_b = C_SEL_EX;
        end else if (w_mem_hit_rt) begin
            w_next_sel_b = C_SEL_MEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_wr_en    <= 1'b0;
            r_ex_is_load  <= 1'b0;
            r_ex_rd       <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_rd      <= '0;
            r_sel_a       <= C_SEL_RF;
            r_sel_b       <= C_SEL_RF;
            r_stall_count <= '0;
        end else begin
            r_mem_wr_en <= r_ex_wr_en;
            r_mem_rd    <= r_ex_rd;
            if (w_bubble) begin
                r_ex_wr_en   <= 1'b0;
                r_ex_is_load <= 1'b0;
                r_ex_rd      <= '0;
                r_sel_a      <= C_SEL_RF;
                r_sel_b      <= C_SEL_RF;
            end else begin
                r_ex_wr_en   <= id_wr_en;
                r_ex_is_load <= id_is_load;
                r_ex_rd      <= id_rd;
                r_sel_a      <= w_next_sel_a;
                r_sel_b      <= w_next_sel_b;
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + C_CNT_ONE;
            end
        end
    end

    assign stall       = w_stall;
    assign fwd_sel_a   = r_sel_a;
    assign fwd_sel_b   = r_sel_b;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fwd_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_sel_ctrl
//  Brief    : Directed self-checking bench for fwd_sel_ctrl (16-bit and
//             2-bit stall counter instances driven in parallel).
//  Revision : 1.0
// ============================================================================
module tb_fwd_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_wr_en;
    logic [4:0] id_rd;
    logic       id_is_load;
    logic       flush;

    logic        stall;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [15:0] stall_count;
    logic        stall_s;
    logic [1:0]  fwd_sel_a_s;
    logic [1:0]  fwd_sel_b_s;
    logic [1:0]  stall_count_s;

    always #5 clk = ~clk;

    fwd_sel_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush), .stall(stall),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_count(stall_count)
    );

    fwd_sel_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush), .stall(stall_s),
        .fwd_sel_a(fwd_sel_a_s), .fwd_sel_b(fwd_sel_b_s), .stall_count(stall_count_s)
    );

    typedef struct {
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive, check stall, push expected EX outputs,
    // clock once, then pop and compare.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic wr,
                        input logic [4:0] rd, input logic ld, input logic fl,
                        input logic es, input logic [1:0] ea, input logic [1:0] eb,
                        input logic [15:0] ec, input string tag);
        exp_t e;
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_uses_rs = urs;  id_uses_rt = urt;
        id_wr_en = wr; id_rd = rd;  id_is_load = ld;  flush = fl;
        #1;
        chk({tag, "/stall"}, {15'd0, stall}, {15'd0, es});
        chk({tag, "/stall_s"}, {15'd0, stall_s}, {15'd0, es});
        sbq.push_back('{sel_a: ea, sel_b: eb, cnt: ec, tag: tag});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.tag, "/sel_a"}, {14'd0, fwd_sel_a}, {14'd0, e.sel_a});
        chk({e.tag, "/sel_b"}, {14'd0, fwd_sel_b}, {14'd0, e.sel_b});
        chk({e.tag, "/count"}, stall_count, e.cnt);
        chk({e.tag, "/count_s"}, {14'd0, stall_count_s}, (e.cnt > 16'd3) ? 16'd3 : e.cnt);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_wr_en = 1'b0; id_rd = '0; id_is_load = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset/stall", {15'd0, stall}, 16'd0);
        chk("reset/sel_a", {14'd0, fwd_sel_a}, 16'd0);
        chk("reset/sel_b", {14'd0, fwd_sel_b}, 16'd0);
        chk("reset/count", stall_count, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        //    v  rs  rt  urs urt wr rd  ld fl  es  a  b  cnt
        // ALU forwarding from EX
        step(1, 1,  2,  0,  0,  1, 5,  0, 0,  0, 0, 0, 0, "alu_wr5");
        step(1, 5,  6,  1,  1,  0, 0,  0, 0,  0, 2, 0, 0, "alu_rd5");
        // Two-deep: $7 in MEM, $8 in EX
        step(1, 0,  0,  0,  0,  1, 7,  0, 0,  0, 0, 0, 0, "deep_wr7");
        step(1, 0,  0,  0,  0,  1, 8,  0, 0,  0, 0, 0, 0, "deep_wr8");
        step(1, 8,  7,  1,  1,  0, 0,  0, 0,  0, 2, 1, 0, "deep_rd");
        // $7 in both EX and MEM: EX wins; rs=0 never forwards
        step(1, 0,  0,  0,  0,  1, 7,  0, 0,  0, 0, 0, 0, "both_wr7a");
        step(1, 0,  0,  0,  0,  1, 7,  0, 0,  0, 0, 0, 0, "both_wr7b");
        step(1, 0,  7,  1,  1,  0, 0,  0, 0,  0, 0, 2, 0, "both_rd");
        // Load-use: one stall, then MEM/WB forward on both operands
        step(1, 0,  0,  0,  0,  1, 3,  1, 0,  0, 0, 0, 0, "lu_load3");
        step(1, 3,  3,  1,  1,  0, 0,  0, 0,  1, 0, 0, 1, "lu_stall");
        step(1, 3,  3,  1,  1,  0, 0,  0, 0,  0, 1, 1, 1, "lu_resume");
        // Register zero: load to $0 neither stalls nor forwards
        step(1, 0,  0,  0,  0,  1, 0,  1, 0,  0, 0, 0, 1, "z_load0");
        step(1, 0,  0,  1,  0,  0, 0,  0, 0,  0, 0, 0, 1, "z_rd_ex");
        step(1, 0,  0,  1,  0,  0, 0,  0, 0,  0, 0, 0, 1, "z_rd_mem");
        // Flush beats hazard; the load then forwards from MEM
        step(1, 0,  0,  0,  0,  1, 4,  1, 0,  0, 0, 0, 1, "fl_load4");
        step(1, 4,  0,  1,  0,  0, 0,  0, 1,  0, 0, 0, 1, "fl_flush");
        step(1, 4,  0,  1,  0,  0, 0,  0, 0,  0, 1, 0, 1, "fl_after");
        // Invalid ID slot becomes a bubble even with wr_en set
        step(0, 0,  0,  0,  0,  1, 9,  0, 0,  0, 0, 0, 1, "inv_wr9");
        step(1, 9,  9,  1,  1,  0, 0,  0, 0,  0, 0, 0, 1, "inv_rd9");
        // Reset asserted during a stall cycle
        step(1, 0,  0,  0,  0,  1, 10, 0, 0,  0, 0, 0, 1, "rs_wr10");
        step(1, 10, 0,  1,  0,  1, 6,  1, 0,  0, 2, 0, 1, "rs_load6");
        id_valid = 1'b1; id_rs = 5'd6; id_uses_rs = 1'b1; id_wr_en = 1'b0;
        id_rd = '0; id_is_load = 1'b0;
        #1;
        chk("rs_pre/stall", {15'd0, stall}, 16'd1);
        rst = 1'b1;
        #1;
        chk("rs_mid/stall", {15'd0, stall}, 16'd0);
        chk("rs_mid/sel_a", {14'd0, fwd_sel_a}, 16'd0);
        chk("rs_mid/count", stall_count, 16'd0);
        chk("rs_mid/stall_s", {15'd0, stall_s}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        // Saturation: five load-use pairs
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0, 0, 0, 1, 3, 1, 0,  0, 0, 0, 16'(i - 1), "sat_load");
            step(1, 3, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 16'(i),     "sat_stall");
        end
        chk("sat/final_s", {14'd0, stall_count_s}, 16'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
